// File: rtl/free_list_pkg.sv
// Shared widths and sizes for the rename-stage physical-register free list.
package free_list_pkg;
  localparam int PR_WIDTH = 7;
  localparam int AR_WIDTH = 5;
  localparam int NUM_PR   = 1 << PR_WIDTH;
  localparam int NUM_AR   = 1 << AR_WIDTH;
  localparam int FL_SIZE  = NUM_PR - NUM_AR;
  localparam int PTR_W    = 7;
  localparam int CNT_W    = 7;

  typedef logic [PR_WIDTH-1:0] pr_tag_t;
  typedef logic [PTR_W-1:0]    fl_ptr_t;
endpackage

// File: rtl/fl_ptr_add.sv
// Free-list pointer plus 0/1/2, wrapping modulo FL_SIZE (not a power of two).
module fl_ptr_add
  import free_list_pkg::*;
(
  input  fl_ptr_t    ptr,
  input  logic [1:0] inc,
  output fl_ptr_t    sum
);

  logic [PTR_W:0] raw;

  always_comb begin
    raw = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, inc};
    sum = (raw >= (PTR_W+1)'(FL_SIZE)) ? PTR_W'(raw - (PTR_W+1)'(FL_SIZE)) : raw[PTR_W-1:0];
  end

endmodule

// File: rtl/free_list.sv
// Circular free list for a 2-wide R10K rename stage: 2 allocs, 2 frees, 1-cycle flush.
// Optional FL_RETIRE_BYPASS_EN lets tags retiring this cycle cover an allocation shortfall.
module free_list
  import free_list_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       rob_dispatch_num,
  input  logic             rob_ar_a_valid,
  input  logic             rob_ar_b_valid,
  input  logic [1:0]       rob_retire_num,
  input  logic             rob_told0_valid,
  input  logic             rob_told1_valid,
  input  pr_tag_t          rob_told0,
  input  pr_tag_t          rob_told1,
  input  logic             rob_mispredict,
  output pr_tag_t          fl_pr0,
  output pr_tag_t          fl_pr1,
  output logic [1:0]       fl_avail_num,
  output logic [CNT_W-1:0] fl_count
);

  pr_tag_t          entries [FL_SIZE];
  fl_ptr_t          head, tail, head_p1, head_next, tail_p1, tail_next;
  logic [CNT_W-1:0] count;
  logic             alloc_a, alloc_b, free0, free1, byp_ok;
  logic [1:0]       alloc, nfree, grant, nbyp, head_inc, nkeep;
  logic [CNT_W:0]   supply;
  pr_tag_t          f_tag0, f_tag1, k_tag0, pool0, pool1;

  function automatic logic [1:0] sat2(input logic [CNT_W:0] v);
    return (v >= (CNT_W+1)'(2)) ? 2'd2 : v[1:0];
  endfunction

  function automatic logic [1:0] min2(input logic [1:0] a, input logic [CNT_W:0] b);
    return ({{(CNT_W-1){1'b0}}, a} > b) ? b[1:0] : a;
  endfunction

  always_comb begin
    alloc_a = (rob_dispatch_num != 2'd0) && rob_ar_a_valid;
    alloc_b = (rob_dispatch_num == 2'd2) && rob_ar_b_valid;
    alloc   = {1'b0, alloc_a} + {1'b0, alloc_b};
    free0   = (rob_retire_num != 2'd0) && rob_told0_valid && (count != CNT_W'(FL_SIZE));
    free1   = (rob_retire_num == 2'd2) && rob_told1_valid && (count != CNT_W'(FL_SIZE));
    nfree   = {1'b0, free0} + {1'b0, free1};
    // Freed tags in write order: a lone told1 takes the first slot.
    f_tag0  = free0 ? rob_told0 : rob_told1;
    f_tag1  = rob_told1;
    byp_ok  = 1'b0;
`ifdef FL_RETIRE_BYPASS_EN
    byp_ok  = !rob_mispredict;
`endif
    supply   = {1'b0, count} + (byp_ok ? {{(CNT_W-1){1'b0}}, nfree} : '0);
    grant    = rob_mispredict ? 2'd0 : min2(alloc, supply);
    nbyp     = ({{(CNT_W-1){1'b0}}, grant} > {1'b0, count}) ? grant - count[1:0] : 2'd0;
    head_inc = grant - nbyp;
    nkeep    = nfree - nbyp;
    k_tag0   = (nbyp == 2'd0) ? f_tag0 : f_tag1;
  end

  // Allocation pool: stored tags first, then this cycle's frees when bypassing.
  always_comb begin
    pool0 = entries[head];
    pool1 = entries[head_p1];
    if (byp_ok) begin
      if (count == '0) begin
        pool0 = f_tag0;
        pool1 = f_tag1;
      end else if (count == CNT_W'(1)) begin
        pool1 = f_tag0;
      end
    end
    fl_pr0       = pool0;
    fl_pr1       = alloc_a ? pool1 : pool0;
    fl_avail_num = sat2(supply);
    fl_count     = count;
  end

  fl_ptr_add u_head_p1   (.ptr(head), .inc(2'd1),     .sum(head_p1));
  fl_ptr_add u_head_next (.ptr(head), .inc(head_inc), .sum(head_next));
  fl_ptr_add u_tail_p1   (.ptr(tail), .inc(2'd1),     .sum(tail_p1));
  fl_ptr_add u_tail_next (.ptr(tail), .inc(nkeep),    .sum(tail_next));

  // Flush: slots from tail to head hold the squashed tags in program order, so head jumps to tail.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FL_SIZE; i++) entries[i] <= PR_WIDTH'(NUM_AR + i);
      head  <= '0;
      tail  <= '0;
      count <= CNT_W'(FL_SIZE);
    end else begin
      if (nkeep != 2'd0) entries[tail]    <= k_tag0;
      if (nkeep == 2'd2) entries[tail_p1] <= f_tag1;
      tail  <= tail_next;
      head  <= rob_mispredict ? tail_next : head_next;
      count <= rob_mispredict ? CNT_W'(FL_SIZE) : (count - {5'b0, head_inc} + {5'b0, nkeep});
    end
  end

endmodule

// File: tb/tb_free_list.sv
// Bench for free_list: directed scenarios then random traffic against a rename/ROB reference model.
module tb_free_list;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] rob_dispatch_num, rob_retire_num, fl_avail_num;
  logic       rob_ar_a_valid, rob_ar_b_valid, rob_told0_valid, rob_told1_valid, rob_mispredict;
  logic [6:0] rob_told0, rob_told1, fl_pr0, fl_pr1, fl_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit dest;
    int ar;
    int t;
    int told;
  } rob_t;

  int   fq[$];
  rob_t rob[$];
  int   ar_q[$];
  int   spec_map[32];
  int   ret_map[32];

  free_list dut (
    .clock(clock), .reset(reset),
    .rob_dispatch_num(rob_dispatch_num), .rob_ar_a_valid(rob_ar_a_valid),
    .rob_ar_b_valid(rob_ar_b_valid), .rob_retire_num(rob_retire_num),
    .rob_told0_valid(rob_told0_valid), .rob_told1_valid(rob_told1_valid),
    .rob_told0(rob_told0), .rob_told1(rob_told1), .rob_mispredict(rob_mispredict),
    .fl_pr0(fl_pr0), .fl_pr1(fl_pr1), .fl_avail_num(fl_avail_num), .fl_count(fl_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    checks++;
    assert (obs === 32'(exp)) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    rob_dispatch_num = 2'd0; rob_ar_a_valid = 1'b0; rob_ar_b_valid = 1'b0;
    rob_retire_num = 2'd0; rob_told0_valid = 1'b0; rob_told1_valid = 1'b0;
    rob_told0 = 7'd0; rob_told1 = 7'd0; rob_mispredict = 1'b0;
  endtask

  task automatic model_reset();
    fq.delete(); rob.delete(); ar_q.delete();
    for (int i = 32; i < 128; i++) fq.push_back(i);
    for (int i = 0; i < 32; i++) begin spec_map[i] = i; ret_map[i] = i; end
  endtask

  task automatic hard_reset();
    @(negedge clock);
    idle_inputs();
    reset = 1'b1;
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  function automatic int next_ar();
    if (ar_q.size() > 0) return ar_q.pop_front();
    return int'($urandom_range(0, 31));
  endfunction

  task automatic dispatch_slot(input bit v, input int grant, inout int used, inout bit go,
                               input int pool[$], inout rob_t newi[$]);
    rob_t e;
    e.dest = 1'b0; e.ar = 0; e.t = 0; e.told = 0;
    if (!v) newi.push_back(e);
    else if (used < grant) begin
      e.dest = 1'b1; e.ar = next_ar(); e.t = pool[used]; e.told = spec_map[e.ar];
      spec_map[e.ar] = e.t;
      used++;
      newi.push_back(e);
    end else go = 1'b0;
  endtask

  // One cycle: drive, check combinational outputs against the model, clock, advance the model.
  task automatic step(input int dnum, input bit a, input bit b, input int rnum, input bit misp);
    int   pool[$];
    int   freed[$];
    int   nxt[$];
    rob_t newi[$];
    rob_t e;
    int   alloc_a, alloc_b, nalloc, grant, used;
    bit   go;
    if (rnum > rob.size()) rnum = rob.size();
    @(negedge clock);
    rob_dispatch_num = 2'(dnum); rob_ar_a_valid = a; rob_ar_b_valid = b;
    rob_retire_num = 2'(rnum); rob_mispredict = misp;
    rob_told0_valid = 1'b0; rob_told1_valid = 1'b0;
    rob_told0 = 7'($urandom); rob_told1 = 7'($urandom);
    if (rnum >= 1 && rob[0].dest) begin
      rob_told0_valid = 1'b1; rob_told0 = 7'(rob[0].told); freed.push_back(rob[0].told);
    end
    if (rnum == 2 && rob[1].dest) begin
      rob_told1_valid = 1'b1; rob_told1 = 7'(rob[1].told); freed.push_back(rob[1].told);
    end
    foreach (fq[i]) pool.push_back(fq[i]);
`ifdef FL_RETIRE_BYPASS_EN
    if (!misp) foreach (freed[i]) pool.push_back(freed[i]);
`endif
    alloc_a = (dnum >= 1 && a) ? 1 : 0;
    alloc_b = (dnum == 2 && b) ? 1 : 0;
    nalloc  = alloc_a + alloc_b;
    grant   = misp ? 0 : ((nalloc < pool.size()) ? nalloc : pool.size());
    #1;
    chk("count", 32'(fl_count), fq.size());
    chk("avail", 32'(fl_avail_num), (pool.size() >= 2) ? 2 : pool.size());
    if (pool.size() > 0) chk("pr0", 32'(fl_pr0), pool[0]);
    if (alloc_b == 1 && pool.size() > alloc_a) chk("pr1", 32'(fl_pr1), pool[alloc_a]);
    used = 0;
    go = !misp && dnum >= 1;
    if (go) dispatch_slot(a, grant, used, go, pool, newi);
    if (go && dnum == 2) dispatch_slot(b, grant, used, go, pool, newi);
    @(posedge clock);
    #1;
    idle_inputs();
    repeat (rnum) begin
      e = rob.pop_front();
      if (e.dest) ret_map[e.ar] = e.t;
    end
    if (misp) begin
      foreach (rob[i]) if (rob[i].dest) nxt.push_back(rob[i].t);
      foreach (fq[i]) nxt.push_back(fq[i]);
      foreach (freed[i]) nxt.push_back(freed[i]);
      fq = nxt;
      rob.delete();
      spec_map = ret_map;
    end else begin
      foreach (freed[i]) fq.push_back(freed[i]);
      repeat (grant) void'(fq.pop_front());
      foreach (newi[i]) rob.push_back(newi[i]);
    end
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    model_reset();
    #2;
    rob_dispatch_num = 2'd2; rob_ar_a_valid = 1'b1; rob_ar_b_valid = 1'b1;
    #1;
    chk("rst_pr0", 32'(fl_pr0), 32);
    chk("rst_pr1", 32'(fl_pr1), 33);
    chk("rst_avail", 32'(fl_avail_num), 2);
    chk("rst_count", 32'(fl_count), 96);
    idle_inputs();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Asynchronous reset in the middle of a cycle after 10 allocations.
    repeat (5) step(2, 1, 1, 0, 0);
    @(negedge clock);
    #2;
    rob_dispatch_num = 2'd2; rob_ar_a_valid = 1'b1; rob_ar_b_valid = 1'b1;
    reset = 1'b1;
    #1;
    chk("async_pr0", 32'(fl_pr0), 32);
    chk("async_pr1", 32'(fl_pr1), 33);
    chk("async_count", 32'(fl_count), 96);
    idle_inputs();
    model_reset();
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Lone slot b takes the head tag.
    step(2, 0, 1, 0, 0);
    chk("loneb_count", 32'(fl_count), 95);
    chk("loneb_head", 32'(fl_pr0), 33);

    // Drain completely, over-request, then refill and reissue.
    hard_reset();
    repeat (48) step(2, 1, 1, 0, 0);
    chk("drain_count", 32'(fl_count), 0);
    chk("drain_avail", 32'(fl_avail_num), 0);
    step(2, 1, 1, 0, 0);
    chk("over_count", 32'(fl_count), 0);
    chk("over_head", 32'(fl_pr0), 32);
    repeat (48) step(0, 0, 0, 2, 0);
    chk("refill_count", 32'(fl_count), 96);
    repeat (6) step(2, 1, 1, 0, 0);

    // Retire told 40/41 while dispatching two with only one tag stored.
    hard_reset();
    for (int i = 0; i < 10; i++) ar_q.push_back(i);
    repeat (5) step(2, 1, 1, 0, 0);
    ar_q.push_back(8); ar_q.push_back(9);
    step(2, 1, 1, 0, 0);
    repeat (5) step(0, 0, 0, 2, 0);
    repeat (46) step(2, 1, 1, 0, 0);
    step(1, 1, 0, 0, 0);
    chk("short_before", 32'(fl_count), 1);
    step(2, 1, 1, 2, 0);
`ifdef FL_RETIRE_BYPASS_EN
    chk("short_after", 32'(fl_count), 1);
`else
    chk("short_after", 32'(fl_count), 2);
`endif

    // Mispredict with one retirement in the flush cycle.
    hard_reset();
    ar_q.push_back(3); ar_q.push_back(7); ar_q.push_back(9);
    repeat (3) step(2, 1, 1, 0, 0);
    step(0, 0, 0, 2, 0);
    step(0, 0, 0, 1, 1);
    chk("flush_count", 32'(fl_count), 96);
    chk("flush_pr0", 32'(fl_pr0), 35);

    // Random traffic with occasional flushes.
    hard_reset();
    for (int c = 0; c < 2000; c++) begin
      int rn;
      rn = ((c % 400) < 200) ? int'($urandom_range(0, 1)) : int'($urandom_range(0, 2));
      step(int'($urandom_range(0, 2)), 1'($urandom), 1'($urandom), rn,
           ($urandom_range(0, 39) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
